// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with synchronizer, glitch/break handling,
// one-byte holding register, frame-error pulse and sticky overrun flag.
//   HCLK          clock, HRESET async active-low reset
//   RxD           serial line in (async, idle high, LSB first)
//   RxD_data      last accepted byte, RxD_valid byte unconsumed
//   RxD_ack       consumer takes RxD_data (only while RxD_valid=1)
//   RxD_frame_err one-cycle pulse on low stop bit
//   RxD_overrun   sticky: good frame dropped, holding register full
//   RxD_busy      receiver not idle
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       RxD,
  input  logic       RxD_ack,
  output logic [7:0] RxD_data,
  output logic       RxD_valid,
  output logic       RxD_frame_err,
  output logic       RxD_overrun,
  output logic       RxD_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_meta;
  logic            rxs;
  logic            good_frame;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  // Stop bit sampled high this cycle: the byte in shreg is complete.
  assign good_frame = (state == STOP) && (cnt == FULL) && rxs;
  assign RxD_busy   = (state != IDLE);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      RxD_data      <= '0;
      RxD_valid     <= 1'b0;
      RxD_frame_err <= 1'b0;
      RxD_overrun   <= 1'b0;
    end else begin
      RxD_frame_err <= 1'b0;

      // An ack in the completing cycle frees the slot for the new byte.
      if (good_frame) begin
        if (!RxD_valid || RxD_ack) begin
          RxD_data  <= shreg;
          RxD_valid <= 1'b1;
        end else begin
          RxD_overrun <= 1'b1;
        end
      end else if (RxD_valid && RxD_ack) begin
        RxD_valid   <= 1'b0;
        RxD_overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              RxD_frame_err <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at CLKS_PER_BIT=16.
// Transaction-level holding-register model, randomized frames and acks.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       RxD;
  logic       RxD_ack;
  logic [7:0] RxD_data;
  logic       RxD_valid;
  logic       RxD_frame_err;
  logic       RxD_overrun;
  logic       RxD_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .RxD           (RxD),
    .RxD_ack       (RxD_ack),
    .RxD_data      (RxD_data),
    .RxD_valid     (RxD_valid),
    .RxD_frame_err (RxD_frame_err),
    .RxD_overrun   (RxD_overrun),
    .RxD_busy      (RxD_busy)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int ferr_seen = 0;
  int exp_ferr = 0;

  logic [7:0] exp_q[$];
  bit         m_pending;
  bit         m_overrun;
  logic [7:0] m_data;

  bit prev_valid = 1'b0;
  bit prev_ack = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: a new byte is presented when valid rises, or when valid
  // stays high across an edge where the consumer acked (replacement).
  always @(negedge HCLK) begin
    if (!HRESET) begin
      prev_valid = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (RxD_valid && (!prev_valid || prev_ack)) begin
        if (!prev_valid) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h expected=none", RxD_data);
        end else begin
          chk("sb_data", RxD_data, exp_q.pop_front());
        end
      end
      if (RxD_frame_err) ferr_seen++;
      prev_valid = RxD_valid;
      prev_ack = RxD_ack;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ack_pulse();
    RxD_ack = 1'b1;
    if (m_pending) begin
      m_pending = 1'b0;
      m_overrun = 1'b0;
    end
    tick(1);
    RxD_ack = 1'b0;
  endtask

  // Drive one 8N1 frame; the model decides what the holding register does.
  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit ack_end, input int abort_at);
    int j;
    if (abort_at < 0) begin
      if (!stop_ok) begin
        exp_ferr++;
      end else if (!m_pending || ack_end) begin
        exp_q.push_back(b);
        m_data = b;
        m_pending = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_at) return;
      j = c / CPB;
      if (j == 0) RxD = 1'b0;
      else if (j == 9) RxD = stop_ok;
      else RxD = b[j-1];
      // stop sample lands on the edge closing cycle 9.5*CPB + ~3
      RxD_ack = ack_end && (c == 3 + CPB / 2 + 9 * CPB - 1);
      if (c == 0) start_cyc = cyc;
      tick(1);
    end
    RxD_ack = 1'b0;
  endtask

  task automatic post_check(input string tag, input bit stop_ok);
    @(negedge HCLK);
    chk({tag, "_valid"}, RxD_valid, m_pending);
    chk({tag, "_overrun"}, RxD_overrun, m_overrun);
    chk({tag, "_data"}, RxD_data, m_data);
    chk({tag, "_busy"}, RxD_busy, !stop_ok);
    tick(1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_data"}, RxD_data, 0);
    chk({tag, "_valid"}, RxD_valid, 0);
    chk({tag, "_ferr"}, RxD_frame_err, 0);
    chk({tag, "_overrun"}, RxD_overrun, 0);
    chk({tag, "_busy"}, RxD_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int ferr0;
    int bc;
    int lat;
    int w;
    logic [7:0] b;
    bit ok;
    int gap;
    int ap;
    bit do_ack;

    HRESET = 1'b0;
    RxD = 1'b1;
    RxD_ack = 1'b0;
    m_pending = 1'b0;
    m_overrun = 1'b0;
    m_data = 8'h00;
    #1;
    reset_checks("rst");
    tick(3);
    HRESET = 1'b1;
    tick(4);

    // single byte, latency and ack handshake
    send(8'h55, 1'b1, 1'b0, -1);
    post_check("f55", 1'b1);
    lat = rise_cyc - start_cyc;
    chk("lat_lo", lat >= 2 + CPB / 2 + 9 * CPB + 1, 1);
    chk("lat_hi", lat <= 2 + CPB / 2 + 9 * CPB + 3, 1);
    tick(5);
    @(negedge HCLK);
    chk("hold_valid", RxD_valid, 1);
    tick(1);
    ack_pulse();
    @(negedge HCLK);
    chk("ack_valid", RxD_valid, 0);
    tick(1);

    // short glitch on the line
    ferr0 = ferr_seen;
    bc = 0;
    RxD = 1'b0;
    tick(4);
    RxD = 1'b1;
    repeat (20) begin
      @(negedge HCLK);
      if (RxD_busy) bc++;
    end
    chk("glitch_busy_seen", bc > 0, 1);
    chk("glitch_busy_end", RxD_busy, 0);
    chk("glitch_valid", RxD_valid, 0);
    chk("glitch_ferr", ferr_seen, ferr0);
    tick(1);

    // framing error followed by a held break
    send(8'hA3, 1'b0, 1'b0, -1);
    post_check("fA3", 1'b0);
    bc = 0;
    repeat (40) begin
      @(negedge HCLK);
      if (!RxD_busy) bc++;
    end
    chk("break_busy", bc, 0);
    tick(1);
    RxD = 1'b1;
    w = 0;
    while (RxD_busy && w < 10) begin
      tick(1);
      w++;
    end
    chk("break_exit", RxD_busy, 0);
    chk("break_ferr", ferr_seen, ferr0 + 1);
    chk("break_valid", RxD_valid, 0);
    send(8'h3C, 1'b1, 1'b0, -1);
    post_check("f3C", 1'b1);
    ack_pulse();

    // randomized frames, stop errors, acks and overruns
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      ok = ($urandom_range(7, 0) != 0);
      send(b, ok, 1'b0, -1);
      post_check("rnd", ok);
      RxD = 1'b1;
      gap = $urandom_range(20, ok ? 1 : 4);
      ap = $urandom_range(gap - 1, 0);
      do_ack = ($urandom_range(9, 0) < 6);
      for (int g = 0; g < gap; g++) begin
        if (g == ap && do_ack) ack_pulse();
        else tick(1);
      end
    end
    if (m_pending) ack_pulse();
    tick(2);

    // overrun: second byte dropped, one ack clears everything
    send(8'h12, 1'b1, 1'b0, -1);
    post_check("ov12", 1'b1);
    send(8'h34, 1'b1, 1'b0, -1);
    post_check("ov34", 1'b1);
    chk("ov_data", RxD_data, 8'h12);
    chk("ov_flag", RxD_overrun, 1);
    ack_pulse();
    @(negedge HCLK);
    chk("ov_ack_valid", RxD_valid, 0);
    chk("ov_ack_flag", RxD_overrun, 0);
    tick(1);

    // ack in the exact completing cycle replaces the byte
    send(8'h12, 1'b1, 1'b0, -1);
    post_check("ac12", 1'b1);
    send(8'h34, 1'b1, 1'b1, -1);
    post_check("ac34", 1'b1);
    chk("ac_data", RxD_data, 8'h34);
    chk("ac_overrun", RxD_overrun, 0);

    // leave a byte pending with overrun set, then reset mid-frame
    send(8'h56, 1'b1, 1'b0, -1);
    post_check("pre_rst", 1'b1);
    send(8'hFF, 1'b1, 1'b0, 5 * CPB + CPB / 2);
    #2;
    HRESET = 1'b0;
    #1;
    reset_checks("midrst");
    RxD = 1'b1;
    exp_q.delete();
    m_pending = 1'b0;
    m_overrun = 1'b0;
    m_data = 8'h00;
    tick(2);
    HRESET = 1'b1;
    tick(5);
    send(8'h81, 1'b1, 1'b0, -1);
    post_check("f81", 1'b1);
    chk("f81_data", RxD_data, 8'h81);
    ack_pulse();
    tick(3);

    chk("sb_drained", exp_q.size(), 0);
    chk("ferr_count", ferr_seen, exp_ferr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
